// File: rtl/mux_nto1_reg_if.sv
// Handshake and data bundle for the registered N-to-1 multiplexer.
// slave is the mux side, master is the producer/consumer side.
interface mux_nto1_reg_if #(
    parameter int N    = 16,
    parameter int W    = 32,
    parameter int CNTW = 16
);
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  in;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [SELW-1:0] sel;
    logic            mode;
    logic [W-1:0]    out;
    logic [SELW-1:0] out_sel;
    logic            out_valid;
    logic            out_ready;
    logic [CNTW-1:0] xfer_cnt;

    modport master (
        output in, in_valid, sel, mode, out_ready,
        input  in_ready, out, out_sel, out_valid, xfer_cnt
    );

    modport slave (
        input  in, in_valid, sel, mode, out_ready,
        output in_ready, out, out_sel, out_valid, xfer_cnt
    );
endinterface

// File: rtl/mux_nto1_reg.sv
// Registered N-channel multiplexer with explicit-select and
// round-robin modes, valid/ready on both sides and a transfer counter.
module mux_nto1_reg #(
    parameter int N    = 16,
    parameter int W    = 32,
    parameter int CNTW = 16
) (
    input  logic           clk,
    input  logic           rst,
    mux_nto1_reg_if.slave  bus
);
    localparam int SELW = $clog2(N);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nxt;
    logic [SELW-1:0] c;
    logic            hit;
    logic            space;
    logic            take;
    logic [W-1:0]    data;
    logic [W-1:0]    out_q;
    logic [SELW-1:0] sel_q;
    logic            vld_q;
    logic [CNTW-1:0] cnt_q;

    // Pick the channel: explicit sel, or first valid from ptr upward.
    always_comb begin
        int j;
        logic [SELW-1:0] idx;
        j   = 0;
        idx = '0;
        hit = 1'b0;
        c   = '0;
        if (bus.mode) begin
            for (int i = 0; i < N; i++) begin
                j = int'(ptr) + i;
                if (j >= N) j = j - N;
                idx = SELW'(j);
                if (!hit && bus.in_valid[idx]) begin
                    hit = 1'b1;
                    c   = idx;
                end
            end
        end else if (int'(bus.sel) < N) begin
            hit = 1'b1;
            c   = bus.sel;
        end
    end

    // Fetch the chosen channel's word with constant part-selects.
    always_comb begin
        data = '0;
        for (int k = 0; k < N; k++) begin
            if (c == SELW'(k)) data = bus.in[k*W +: W];
        end
    end

    // Grant the chosen channel whenever the output register can load.
    always_comb begin
        space        = !vld_q || bus.out_ready;
        bus.in_ready = '0;
        if (!rst && space && hit) bus.in_ready[c] = 1'b1;
        take    = !rst && space && hit && bus.in_valid[c];
        ptr_nxt = (int'(c) == N - 1) ? '0 : c + 1'b1;
    end

    // Output register, valid flag and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= '0;
            vld_q <= 1'b0;
            ptr   <= '0;
        end else if (take) begin
            out_q <= data;
            sel_q <= c;
            vld_q <= 1'b1;
            if (bus.mode) ptr <= ptr_nxt;
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (vld_q && bus.out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = vld_q;
    assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: a 16-channel instance for the
// main scenarios and a 12-channel, 4-bit-counter instance for edges.
module tb_mux_nto1_reg;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux_nto1_reg_if #(.N(16), .W(8), .CNTW(16)) if0 ();
    mux_nto1_reg_if #(.N(12), .W(8), .CNTW(4))  if1 ();

    mux_nto1_reg #(.N(16), .W(8), .CNTW(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mux_nto1_reg #(.N(12), .W(8), .CNTW(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr [7];
        checks   = 0;
        failures = 0;
        rr = '{2, 5, 15, 2, 5, 15, 2};

        for (int k = 0; k < 16; k++) if0.in[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 12; k++) if1.in[k*8 +: 8] = 8'(8'h40 + k);
        if0.in_valid  = 16'hFFFF;
        if0.sel       = '0;
        if0.mode      = 1'b0;
        if0.out_ready = 1'b1;
        if1.in_valid  = '0;
        if1.sel       = '0;
        if1.mode      = 1'b0;
        if1.out_ready = 1'b1;

        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_out", 32'(if0.out), 32'h0);
        check("rst_sel", 32'(if0.out_sel), 32'h0);
        check("rst_vld", 32'(if0.out_valid), 32'h0);
        check("rst_cnt", 32'(if0.xfer_cnt), 32'h0);
        check("rst_rdy", 32'(if0.in_ready), 32'h0);
        tick();
        rst = 1'b0;

        // Mode 0 sweep
        for (int s = 0; s < 16; s++) begin
            if0.sel = 4'(s);
            #1;
            check($sformatf("sw_rdy%0d", s), 32'(if0.in_ready),
                  32'(1) << s);
            tick();
            check($sformatf("sw_out%0d", s), 32'(if0.out), 32'(8'h10 + s));
            check($sformatf("sw_sel%0d", s), 32'(if0.out_sel), 32'(s));
            check($sformatf("sw_vld%0d", s), 32'(if0.out_valid), 32'h1);
            check($sformatf("sw_cnt%0d", s), 32'(if0.xfer_cnt), 32'(s));
        end
        if0.in_valid = '0;
        tick();
        check("sw_drain_vld", 32'(if0.out_valid), 32'h0);
        check("sw_drain_out", 32'(if0.out), 32'h1F);
        check("sw_cnt16", 32'(if0.xfer_cnt), 32'd16);

        // Backpressure
        if0.in_valid      = 16'hFFFF;
        if0.sel           = 4'd3;
        if0.in[3*8 +: 8]  = 8'hA5;
        if0.out_ready     = 1'b0;
        tick();
        check("bp_load", 32'(if0.out), 32'hA5);
        if0.in[3*8 +: 8]  = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_rdy%0d", i), 32'(if0.in_ready), 32'h0);
            tick();
            check($sformatf("bp_out%0d", i), 32'(if0.out), 32'hA5);
            check($sformatf("bp_vld%0d", i), 32'(if0.out_valid), 32'h1);
            check($sformatf("bp_cnt%0d", i), 32'(if0.xfer_cnt), 32'd16);
        end
        if0.out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(if0.in_ready), 32'h0008);
        tick();
        check("bp_rel_cnt", 32'(if0.xfer_cnt), 32'd17);
        check("bp_rel_out", 32'(if0.out), 32'h3C);
        check("bp_rel_vld", 32'(if0.out_valid), 32'h1);
        if0.in[3*8 +: 8]  = 8'h13;

        // Round-robin fairness
        if0.mode     = 1'b1;
        if0.in_valid = 16'h8024;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("rr_sel%0d", i), 32'(if0.out_sel), 32'(rr[i]));
            check($sformatf("rr_out%0d", i), 32'(if0.out),
                  32'(8'h10 + rr[i]));
        end

        // Empty round-robin drains the pending word
        if0.in_valid = '0;
        #1;
        check("rr_empty_rdy", 32'(if0.in_ready), 32'h0);
        tick();
        check("rr_empty_vld", 32'(if0.out_valid), 32'h0);
        check("rr_empty_out", 32'(if0.out), 32'h12);
        check("rr_empty_sel", 32'(if0.out_sel), 32'd2);

        // Pointer survives a mode-0 transfer
        if0.mode     = 1'b0;
        if0.sel      = 4'd9;
        if0.in_valid = 16'hFFFF;
        tick();
        check("mx_sel9", 32'(if0.out_sel), 32'd9);
        if0.mode = 1'b1;
        #1;
        check("mx_rdy", 32'(if0.in_ready), 32'h0008);
        tick();
        check("mx_sel3", 32'(if0.out_sel), 32'd3);
        check("mx_out", 32'(if0.out), 32'h13);

        // Async reset during a stall
        if0.mode      = 1'b0;
        if0.sel       = 4'd7;
        if0.out_ready = 1'b0;
        tick();
        check("st_out", 32'(if0.out), 32'h13);
        check("st_sel", 32'(if0.out_sel), 32'd3);
        check("st_vld", 32'(if0.out_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("ar_out", 32'(if0.out), 32'h0);
        check("ar_sel", 32'(if0.out_sel), 32'h0);
        check("ar_vld", 32'(if0.out_valid), 32'h0);
        check("ar_cnt", 32'(if0.xfer_cnt), 32'h0);
        check("ar_rdy", 32'(if0.in_ready), 32'h0);
        #1 rst = 1'b0;
        if0.mode      = 1'b1;
        if0.out_ready = 1'b1;
        #1;
        check("ar_rr_rdy", 32'(if0.in_ready), 32'h0001);
        tick();
        check("ar_rr_sel0", 32'(if0.out_sel), 32'd0);
        check("ar_rr_out0", 32'(if0.out), 32'h10);
        tick();
        check("ar_rr_sel1", 32'(if0.out_sel), 32'd1);
        check("ar_rr_cnt", 32'(if0.xfer_cnt), 32'd1);

        // N=12: select beyond the channel count
        if1.in_valid = 12'hFFF;
        if1.sel      = 4'd13;
        #1;
        check("n12_rdy13", 32'(if1.in_ready), 32'h0);
        tick();
        check("n12_vld13", 32'(if1.out_valid), 32'h0);
        if1.sel = 4'd11;
        #1;
        check("n12_rdy11", 32'(if1.in_ready), 32'h800);
        tick();
        check("n12_out11", 32'(if1.out), 32'h4B);
        check("n12_sel11", 32'(if1.out_sel), 32'd11);
        if1.sel = 4'd13;
        tick();
        check("n12_drain_vld", 32'(if1.out_valid), 32'h0);
        check("n12_drain_out", 32'(if1.out), 32'h4B);
        check("n12_cnt", 32'(if1.xfer_cnt), 32'd1);

        // Counter wrap with a 4-bit counter
        rst = 1'b1;
        #1;
        check("wr_rst_cnt", 32'(if1.xfer_cnt), 32'h0);
        rst = 1'b0;
        if1.sel = 4'd0;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 16) check("wr_cnt15", 32'(if1.xfer_cnt), 32'd15);
            if (e == 17) check("wr_cnt0", 32'(if1.xfer_cnt), 32'd0);
            if (e == 18) check("wr_cnt1", 32'(if1.xfer_cnt), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
